// File: rtl/am_lock_pkg.sv
// am_lock_pkg: shared constants and types for the per-lane alignment-marker lock.
// Holds sync-header codes, AM byte-field offsets, the marker type, the
// lock FSM state type and the 40G / 100G marker tables.
package am_lock_pkg;

    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam logic [1:0] SYNC_DATA = 2'b01;

    // LSB positions of each marker byte inside a 66-bit block
    localparam int M0_LSB   = 2;
    localparam int M1_LSB   = 10;
    localparam int M2_LSB   = 18;
    localparam int BIP3_LSB = 26;
    localparam int M4_LSB   = 34;
    localparam int M5_LSB   = 42;
    localparam int M6_LSB   = 50;
    localparam int BIP7_LSB = 58;

    // The six fixed marker bytes; BIP3/BIP7 are not part of the identity
    typedef struct packed {
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] m2;
        logic [7:0] m4;
        logic [7:0] m5;
        logic [7:0] m6;
    } am_marker_t;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } am_state_t;

    // M4..M6 are always the bitwise inverse of M0..M2
    function automatic am_marker_t make_am(input logic [7:0] m0,
                                           input logic [7:0] m1,
                                           input logic [7:0] m2);
        am_marker_t r;
        r.m0 = m0;
        r.m1 = m1;
        r.m2 = m2;
        r.m4 = ~m0;
        r.m5 = ~m1;
        r.m6 = ~m2;
        return r;
    endfunction

    localparam am_marker_t AM_40G [4] = '{
        make_am(8'h90, 8'h76, 8'h47),
        make_am(8'hF0, 8'hC4, 8'hE6),
        make_am(8'hC5, 8'h65, 8'h9B),
        make_am(8'hA2, 8'h79, 8'h3D)
    };

    localparam am_marker_t AM_100G [20] = '{
        make_am(8'hC1, 8'h68, 8'h21),
        make_am(8'h9D, 8'h71, 8'h8E),
        make_am(8'h59, 8'h4B, 8'hE8),
        make_am(8'h4D, 8'h95, 8'h7B),
        make_am(8'hF5, 8'h07, 8'h09),
        make_am(8'hDD, 8'h14, 8'hC2),
        make_am(8'h9A, 8'h4A, 8'h26),
        make_am(8'h7B, 8'h45, 8'h66),
        make_am(8'hA0, 8'h24, 8'h76),
        make_am(8'h68, 8'hC9, 8'hFB),
        make_am(8'hFD, 8'h6C, 8'h99),
        make_am(8'hB9, 8'h91, 8'h55),
        make_am(8'h5C, 8'hB9, 8'hB2),
        make_am(8'h1A, 8'hF8, 8'hBD),
        make_am(8'h83, 8'hC7, 8'hCA),
        make_am(8'h35, 8'h36, 8'hCD),
        make_am(8'hC4, 8'h31, 8'h4C),
        make_am(8'hAD, 8'hD6, 8'hB7),
        make_am(8'h5F, 8'h66, 8'h2A),
        make_am(8'hC0, 8'hF0, 8'hE5)
    };

endpackage

// File: rtl/am_match.sv
// am_match: combinational compare of one 66-bit block against every marker
// of the selected table (40G for LANE_N=4, 100G for LANE_N=20). Produces a
// one-hot match vector, a hit flag and the encoded lane index.
module am_match
    import am_lock_pkg::*;
#(
    parameter int BLOCK_W = 66,
    parameter int LANE_N  = 4,
    parameter int LANE_W  = $clog2(LANE_N)
) (
    input  logic [BLOCK_W-1:0] block,
    output logic [LANE_N-1:0]  match,
    output logic               hit,
    output logic [LANE_W-1:0]  idx
);

    am_marker_t rx;
    logic       is_ctrl;
    logic       bip_unused;

    assign rx.m0   = block[M0_LSB +: 8];
    assign rx.m1   = block[M1_LSB +: 8];
    assign rx.m2   = block[M2_LSB +: 8];
    assign rx.m4   = block[M4_LSB +: 8];
    assign rx.m5   = block[M5_LSB +: 8];
    assign rx.m6   = block[M6_LSB +: 8];
    assign is_ctrl = (block[1:0] == SYNC_CTRL);

    // BIP bytes carry parity, not identity, so they never take part in the match
    assign bip_unused = ^{block[BIP3_LSB +: 8], block[BIP7_LSB +: 8]};

    for (genvar k = 0; k < LANE_N; k++) begin : g_lane
        am_marker_t ref_am;
        if (LANE_N == 20) begin : g_100g
            assign ref_am = AM_100G[k];
        end else begin : g_40g
            assign ref_am = AM_40G[k];
        end
        assign match[k] = is_ctrl && (rx == ref_am);
    end

    assign hit = |match;

    // One-hot to index; the marker tables guarantee at most one bit is set
    always_comb begin
        idx = '0;
        for (int k = 0; k < LANE_N; k++) begin
            if (match[k]) begin
                idx = idx | LANE_W'(k);
            end
        end
    end

endmodule

// File: rtl/am_lane_lock.sv
// am_lane_lock: alignment-marker lock for one RX PCS lane (40G or 100G).
// Finds a marker, confirms it one AM period later, then tracks markers with
// INV_AM_N-deep hysteresis before dropping lock.
// Optional build macro AM_ERR_CNT_EN adds a 16-bit saturating bad-AM counter
// output am_err_cnt_o that only nreset clears.
module am_lane_lock
    import am_lock_pkg::*;
#(
    parameter int BLOCK_W  = 66,
    parameter int LANE_N   = 4,
    parameter int GAP_N    = 16383,
    parameter int INV_AM_N = 4,
    parameter int LANE_W   = $clog2(LANE_N)
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               signal_ok_i,
    input  logic               valid_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               slip_v_o,
    output logic               lock_v_o,
    output logic [LANE_W-1:0]  lane_o,
    output logic               am_v_o
`ifdef AM_ERR_CNT_EN
    ,
    output logic [15:0]        am_err_cnt_o
`endif
);

    localparam int CNT_W = $clog2(GAP_N + 1);
    localparam int INV_W = $clog2(INV_AM_N + 1);

    if (BLOCK_W != 66) begin : g_bad_block_w
        $error("am_lane_lock: BLOCK_W must be 66");
    end
    if (LANE_N != 4 && LANE_N != 20) begin : g_bad_lane_n
        $error("am_lane_lock: LANE_N must be 4 or 20");
    end

    logic [LANE_N-1:0] match;
    logic              hit;
    logic [LANE_W-1:0] hit_idx;

    am_match #(
        .BLOCK_W (BLOCK_W),
        .LANE_N  (LANE_N),
        .LANE_W  (LANE_W)
    ) u_match (
        .block (block_i),
        .match (match),
        .hit   (hit),
        .idx   (hit_idx)
    );

    am_state_t         state, state_nxt;
    logic [LANE_W-1:0] cand, cand_nxt;
    logic [CNT_W-1:0]  blk_cnt, cnt_nxt;
    logic [INV_W-1:0]  inv_cnt, inv_nxt;
    logic              lock_nxt;
    logic [LANE_W-1:0] lane_nxt;
    logic              slip_nxt;
    logic              am_v_nxt;
    logic              bad_am;
    logic              at_am;

    assign at_am = (blk_cnt == CNT_W'(GAP_N));

    // Next-state and next-output decode; signal loss overrides everything, stalls hold
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = blk_cnt;
        inv_nxt   = inv_cnt;
        lock_nxt  = lock_v_o;
        lane_nxt  = lane_o;
        slip_nxt  = 1'b0;
        am_v_nxt  = 1'b0;
        bad_am    = 1'b0;
        if (!signal_ok_i) begin
            state_nxt = SEARCH;
            cnt_nxt   = '0;
            inv_nxt   = '0;
            lock_nxt  = 1'b0;
        end else if (valid_i) begin
            case (state)
                SEARCH: begin
                    cnt_nxt = '0;
                    if (hit) begin
                        cand_nxt  = hit_idx;
                        state_nxt = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (at_am) begin
                        cnt_nxt = '0;
                        if (match[cand]) begin
                            state_nxt = LOCKED;
                            lock_nxt  = 1'b1;
                            lane_nxt  = cand;
                            inv_nxt   = '0;
                        end else begin
                            slip_nxt  = 1'b1;
                            state_nxt = SEARCH;
                        end
                    end else begin
                        cnt_nxt = blk_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (at_am) begin
                        cnt_nxt  = '0;
                        am_v_nxt = 1'b1;
                        if (match[lane_o]) begin
                            inv_nxt = '0;
                        end else begin
                            bad_am = 1'b1;
                            if (inv_cnt == INV_W'(INV_AM_N - 1)) begin
                                inv_nxt   = '0;
                                lock_nxt  = 1'b0;
                                slip_nxt  = 1'b1;
                                state_nxt = SEARCH;
                            end else begin
                                inv_nxt = inv_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt_nxt = blk_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    cnt_nxt   = '0;
                    inv_nxt   = '0;
                    lock_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= SEARCH;
            cand     <= '0;
            blk_cnt  <= '0;
            inv_cnt  <= '0;
            lock_v_o <= 1'b0;
            lane_o   <= '0;
            slip_v_o <= 1'b0;
            am_v_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            blk_cnt  <= cnt_nxt;
            inv_cnt  <= inv_nxt;
            lock_v_o <= lock_nxt;
            lane_o   <= lane_nxt;
            slip_v_o <= slip_nxt;
            am_v_o   <= am_v_nxt;
        end
    end

`ifdef AM_ERR_CNT_EN
    logic [15:0] err_cnt;

    // Saturating bad-AM count; survives loss of lock, cleared only by reset
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_cnt <= '0;
        end else if (bad_am && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign am_err_cnt_o = err_cnt;
`else
    logic bad_am_unused;
    assign bad_am_unused = bad_am;
`endif

endmodule

// File: tb/tb_am_lane_lock.sv
// tb_am_lane_lock: self-checking bench for am_lane_lock. Three instances share
// one input stream: full-size 40G, full-size 100G and a short-gap 40G copy.
module tb_am_lane_lock;

    localparam int SMALL_GAP = 7;
    localparam int K_DATA    = 0;
    localparam int K_AM      = 1;
    localparam int K_BAD     = 2;

    // Bench-owned marker bytes {M0,M1,M2}
    localparam logic [23:0] TB_AM40 [4] = '{
        24'h907647, 24'hF0C4E6, 24'hC5659B, 24'hA2793D
    };
    localparam logic [23:0] TB_AM100 [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
        24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
        24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
        24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    typedef struct {
        logic       lock;
        logic       slip;
        logic       amv;
        logic [4:0] lane;
    } exp_t;

    typedef struct {
        logic ok;
        logic v;
        int   kind;
        int   lane;
        int   reps;
        logic lock;
        logic slip;
        logic amv;
        int   xlane;
    } vec_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        signal_ok;
    logic        valid;
    logic [65:0] block;

    logic       slip_a, lock_a, amv_a;
    logic [1:0] lane_a;
    logic       slip_b, lock_b, amv_b;
    logic [4:0] lane_b;
    logic       slip_c, lock_c, amv_c;
    logic [1:0] lane_c;
`ifdef AM_ERR_CNT_EN
    logic [15:0] err_a, err_b, err_c;
`endif

    int   checks = 0;
    int   errors = 0;
    int   sel    = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    am_lane_lock #(.LANE_N(4)) u_big40 (
        .clk(clk), .nreset(nreset), .signal_ok_i(signal_ok), .valid_i(valid),
        .block_i(block), .slip_v_o(slip_a), .lock_v_o(lock_a), .lane_o(lane_a),
        .am_v_o(amv_a)
`ifdef AM_ERR_CNT_EN
        , .am_err_cnt_o(err_a)
`endif
    );

    am_lane_lock #(.LANE_N(20)) u_big100 (
        .clk(clk), .nreset(nreset), .signal_ok_i(signal_ok), .valid_i(valid),
        .block_i(block), .slip_v_o(slip_b), .lock_v_o(lock_b), .lane_o(lane_b),
        .am_v_o(amv_b)
`ifdef AM_ERR_CNT_EN
        , .am_err_cnt_o(err_b)
`endif
    );

    am_lane_lock #(.LANE_N(4), .GAP_N(SMALL_GAP)) u_small (
        .clk(clk), .nreset(nreset), .signal_ok_i(signal_ok), .valid_i(valid),
        .block_i(block), .slip_v_o(slip_c), .lock_v_o(lock_c), .lane_o(lane_c),
        .am_v_o(amv_c)
`ifdef AM_ERR_CNT_EN
        , .am_err_cnt_o(err_c)
`endif
    );

    function automatic exp_t mk(input logic lock, input logic slip, input logic amv, input int lane);
        exp_t e;
        e.lock = lock;
        e.slip = slip;
        e.amv  = amv;
        e.lane = 5'(lane);
        return e;
    endfunction

    function automatic logic [65:0] makeBlock(input int kind, input int lane, input bit big);
        logic [65:0] b;
        logic [23:0] m;
        if (kind == K_DATA) begin
            b[31:0]  = $urandom();
            b[63:32] = $urandom();
            b[65:64] = 2'($urandom());
            b[1:0]   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            return b;
        end
        if (big) m = TB_AM100[lane];
        else     m = TB_AM40[lane];
        b[1:0]   = 2'b10;
        b[9:2]   = m[23:16];
        b[17:10] = m[15:8];
        b[25:18] = m[7:0];
        b[33:26] = 8'($urandom());
        b[41:34] = ~m[23:16];
        b[49:42] = ~m[15:8];
        b[57:50] = ~m[7:0];
        b[65:58] = 8'($urandom());
        if (kind == K_BAD) b[12] = ~b[12];
        return b;
    endfunction

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic ok, input logic v, input logic [65:0] blk, input exp_t e);
        @(negedge clk);
        signal_ok = ok;
        valid     = v;
        block     = blk;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t       e;
        logic       a_lock, a_slip, a_amv;
        logic [4:0] a_lane;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        case (sel)
            0:       begin a_lock = lock_a; a_slip = slip_a; a_amv = amv_a; a_lane = {3'b000, lane_a}; end
            1:       begin a_lock = lock_b; a_slip = slip_b; a_amv = amv_b; a_lane = lane_b; end
            default: begin a_lock = lock_c; a_slip = slip_c; a_amv = amv_c; a_lane = {3'b000, lane_c}; end
        endcase
        checkVal({tag, ".lock"}, 16'(a_lock), 16'(e.lock));
        checkVal({tag, ".slip"}, 16'(a_slip), 16'(e.slip));
        checkVal({tag, ".am_v"}, 16'(a_amv), 16'(e.amv));
        if (e.lock) checkVal({tag, ".lane"}, 16'(a_lane), 16'(e.lane));
    endtask

    task automatic step(input logic ok, input logic v, input logic [65:0] blk, input exp_t e, input string tag);
        applyStimulus(ok, v, blk, e);
        checkOutput(tag);
    endtask

    task automatic runData(input int n, input exp_t e, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, makeBlock(K_DATA, 0, 1'b0), e, tag);
    endtask

    task automatic doReset();
        @(negedge clk);
        nreset    = 1'b0;
        signal_ok = 1'b1;
        valid     = 1'b0;
        block     = '0;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Lock the short-gap instance on a 40G lane with a clean AM pair
    task automatic lockSmall(input int lane, input string tag);
        step(1'b1, 1'b1, makeBlock(K_AM, lane, 1'b0), mk(0, 0, 0, 0), {tag, ".am1"});
        runData(SMALL_GAP, mk(0, 0, 0, 0), {tag, ".gap"});
        step(1'b1, 1'b1, makeBlock(K_AM, lane, 1'b0), mk(1, 0, 0, lane), {tag, ".am2"});
    endtask

    task automatic asyncResetCheck(input string tag);
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        checkVal({tag, ".lock"}, 16'(lock_c), 16'd0);
        checkVal({tag, ".slip"}, 16'(slip_c), 16'd0);
        checkVal({tag, ".am_v"}, 16'(amv_c), 16'd0);
        checkVal({tag, ".lane"}, 16'(lane_c), 16'd0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    function automatic void addVec(input logic ok, input logic v, input int kind, input int lane,
                                   input int reps, input logic lock, input logic slip,
                                   input logic amv, input int xlane);
        vec_t r;
        r.ok = ok; r.v = v; r.kind = kind; r.lane = lane; r.reps = reps;
        r.lock = lock; r.slip = slip; r.amv = amv; r.xlane = xlane;
        tbl.push_back(r);
    endfunction

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nvalid;

        nreset    = 1'b0;
        signal_ok = 1'b1;
        valid     = 1'b0;
        block     = '0;
        #12;
        checkVal("rst.lock40",  16'(lock_a), 16'd0);
        checkVal("rst.slip40",  16'(slip_a), 16'd0);
        checkVal("rst.amv40",   16'(amv_a),  16'd0);
        checkVal("rst.lane40",  16'(lane_a), 16'd0);
        checkVal("rst.lock100", 16'(lock_b), 16'd0);
        checkVal("rst.slip100", 16'(slip_b), 16'd0);
        checkVal("rst.amv100",  16'(amv_b),  16'd0);
        checkVal("rst.lane100", 16'(lane_b), 16'd0);
        checkVal("rst.locks",   16'(lock_c), 16'd0);
        checkVal("rst.slips",   16'(slip_c), 16'd0);
        checkVal("rst.amvs",    16'(amv_c),  16'd0);
        checkVal("rst.lanes",   16'(lane_c), 16'd0);
`ifdef AM_ERR_CNT_EN
        checkVal("rst.err", err_c, 16'd0);
`endif
        @(negedge clk);
        nreset = 1'b1;

        // 40G full period, lane 2
        $display("[TB] 40G lane 2 full AM period");
        sel = 0;
        doReset();
        step(1'b1, 1'b1, makeBlock(K_AM, 2, 1'b0), mk(0, 0, 0, 0), "g40.am1");
        runData(16383, mk(0, 0, 0, 0), "g40.gap");
        step(1'b1, 1'b1, makeBlock(K_AM, 2, 1'b0), mk(1, 0, 0, 2), "g40.am2");
        runData(1, mk(1, 0, 0, 2), "g40.after");

        // 100G full period, lane 17, random 1-in-3 stalls
        $display("[TB] 100G lane 17 with stalls");
        sel = 1;
        doReset();
        step(1'b1, 1'b1, makeBlock(K_AM, 17, 1'b1), mk(0, 0, 0, 0), "g100.am1");
        nvalid = 0;
        while (nvalid < 16383) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b1, 1'b0, makeBlock(K_DATA, 0, 1'b1), mk(0, 0, 0, 0), "g100.stall");
            end else begin
                step(1'b1, 1'b1, makeBlock(K_DATA, 0, 1'b1), mk(0, 0, 0, 0), "g100.gap");
                nvalid++;
            end
        end
        step(1'b1, 1'b0, makeBlock(K_AM, 17, 1'b1), mk(0, 0, 0, 0), "g100.stall_am");
        step(1'b1, 1'b1, makeBlock(K_AM, 17, 1'b1), mk(1, 0, 0, 17), "g100.am2");
        step(1'b1, 1'b0, makeBlock(K_DATA, 0, 1'b1), mk(1, 0, 0, 17), "g100.hold");

        // Table-driven short-gap sequence: reject, relock, stalls, bad/good AMs
        $display("[TB] table vectors, GAP_N=%0d", SMALL_GAP);
        sel = 2;
        doReset();
        addVec(1, 1, K_AM,   1, 1, 0, 0, 0, 0);
        addVec(1, 1, K_DATA, 0, 3, 0, 0, 0, 0);
        addVec(1, 0, K_DATA, 0, 2, 0, 0, 0, 0);
        addVec(1, 1, K_DATA, 0, 4, 0, 0, 0, 0);
        addVec(1, 1, K_AM,   3, 1, 0, 1, 0, 0);
        addVec(1, 0, K_DATA, 0, 1, 0, 0, 0, 0);
        addVec(1, 1, K_DATA, 0, 1, 0, 0, 0, 0);
        addVec(1, 1, K_AM,   1, 1, 0, 0, 0, 0);
        addVec(1, 1, K_DATA, 0, 7, 0, 0, 0, 0);
        addVec(1, 1, K_AM,   1, 1, 1, 0, 0, 1);
        addVec(1, 1, K_DATA, 0, 7, 1, 0, 0, 1);
        addVec(1, 0, K_AM,   1, 1, 1, 0, 0, 1);
        addVec(1, 1, K_AM,   1, 1, 1, 0, 1, 1);
        addVec(1, 1, K_DATA, 0, 7, 1, 0, 0, 1);
        addVec(1, 1, K_DATA, 0, 1, 1, 0, 1, 1);
        addVec(1, 1, K_DATA, 0, 3, 1, 0, 0, 1);
        addVec(1, 1, K_AM,   1, 1, 1, 0, 0, 1);
        addVec(1, 1, K_DATA, 0, 3, 1, 0, 0, 1);
        addVec(1, 1, K_AM,   1, 1, 1, 0, 1, 1);
        addVec(1, 1, K_DATA, 0, 7, 1, 0, 0, 1);
        addVec(1, 1, K_AM,   2, 1, 1, 0, 1, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].ok, tbl[i].v, makeBlock(tbl[i].kind, tbl[i].lane, 1'b0),
                     mk(tbl[i].lock, tbl[i].slip, tbl[i].amv, tbl[i].xlane),
                     $sformatf("tbl%0d.%0d", i, r));
            end
        end

        // Hysteresis: 3 bad + 1 good keeps lock, 4 bad drops it
        $display("[TB] lock-loss hysteresis on lane 0");
        doReset();
        lockSmall(0, "hyst.lock");
        for (int i = 0; i < 3; i++) begin
            runData(SMALL_GAP, mk(1, 0, 0, 0), "hyst.gap");
            step(1'b1, 1'b1, makeBlock(K_BAD, 0, 1'b0), mk(1, 0, 1, 0), "hyst.bad_a");
        end
        runData(SMALL_GAP, mk(1, 0, 0, 0), "hyst.gap");
        step(1'b1, 1'b1, makeBlock(K_AM, 0, 1'b0), mk(1, 0, 1, 0), "hyst.good");
        for (int i = 0; i < 3; i++) begin
            runData(SMALL_GAP, mk(1, 0, 0, 0), "hyst.gap");
            step(1'b1, 1'b1, makeBlock(K_BAD, 0, 1'b0), mk(1, 0, 1, 0), "hyst.bad_b");
        end
        runData(SMALL_GAP, mk(1, 0, 0, 0), "hyst.gap");
        step(1'b1, 1'b1, makeBlock(K_AM, 2, 1'b0), mk(0, 1, 1, 0), "hyst.bad4");
        runData(1, mk(0, 0, 0, 0), "hyst.after");
`ifdef AM_ERR_CNT_EN
        checkVal("hyst.err_cnt", err_c, 16'd7);
`endif

        // signal_ok drop, relock, then signal_ok drop on the 4th bad AM
        $display("[TB] signal_ok loss");
        doReset();
        lockSmall(3, "sok.lock");
        step(1'b0, 1'b1, makeBlock(K_DATA, 0, 1'b0), mk(0, 0, 0, 0), "sok.drop");
        lockSmall(3, "sok.relock");
        for (int i = 0; i < 3; i++) begin
            runData(SMALL_GAP, mk(1, 0, 0, 3), "sok.gap");
            step(1'b1, 1'b1, makeBlock(K_BAD, 3, 1'b0), mk(1, 0, 1, 3), "sok.bad");
        end
        runData(SMALL_GAP, mk(1, 0, 0, 3), "sok.gap");
        step(1'b0, 1'b1, makeBlock(K_BAD, 3, 1'b0), mk(0, 0, 0, 0), "sok.bad4_drop");
        runData(1, mk(0, 0, 0, 0), "sok.after");

        // Asynchronous reset while locked and while confirming
        $display("[TB] asynchronous reset");
        doReset();
        lockSmall(2, "ars.lock");
        runData(3, mk(1, 0, 0, 2), "ars.gap");
        asyncResetCheck("ars.locked");
        step(1'b1, 1'b1, makeBlock(K_AM, 2, 1'b0), mk(0, 0, 0, 0), "ars.cand");
        runData(3, mk(0, 0, 0, 0), "ars.confirm");
        asyncResetCheck("ars.confirm");
        lockSmall(2, "ars.relock");

        checkVal("sb.empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
